// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: 3-slot destination scoreboard, RAW stall, taken-branch squash, perf counters.
// Optional PIPE_FWD_EN adds registered forwarding selects and relaxes stalls to load-use.
module pipe_hazard_ctrl #(
  parameter bit          REGFILE_BYPASS = 1'b0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic             id_wen,
  input  logic [4:0]       id_waddr,
  input  logic             id_is_load,
  input  logic             exe_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
`ifdef PIPE_FWD_EN
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`endif
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] waddr;
    logic             is_load;
  } slot_t;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t state_q, state_d;
  slot_t  exe_q, mem_q, wb_q;
  logic   stall_inc, flush_inc;

  // r0 is never a real producer, so a zero destination never matches
  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && (s.waddr != '0) && (s.waddr == r);
  endfunction

  logic rs1_exe, rs1_mem, rs1_wb, rs2_exe, rs2_mem, rs2_wb;
  logic rs1_stall, rs2_stall, hazard, take;

  assign rs1_exe = slot_hit(exe_q, id_rs1);
  assign rs1_mem = slot_hit(mem_q, id_rs1);
  assign rs1_wb  = slot_hit(wb_q,  id_rs1);
  assign rs2_exe = slot_hit(exe_q, id_rs2);
  assign rs2_mem = slot_hit(mem_q, id_rs2);
  assign rs2_wb  = slot_hit(wb_q,  id_rs2);

`ifdef PIPE_FWD_EN
  // EXE/MEM results are forwarded; only a load still in EXE, or an unbypassed WB write, must wait
  assign rs1_stall = (rs1_exe & exe_q.is_load) | (rs1_wb & ~REGFILE_BYPASS);
  assign rs2_stall = (rs2_exe & exe_q.is_load) | (rs2_wb & ~REGFILE_BYPASS);
`else
  assign rs1_stall = rs1_exe | rs1_mem | (rs1_wb & ~REGFILE_BYPASS);
  assign rs2_stall = rs2_exe | rs2_mem | (rs2_wb & ~REGFILE_BYPASS);
`endif

  assign hazard = id_valid & (rs1_stall | (id_use_rs2 & rs2_stall));
  assign take   = exe_branch_taken & exe_q.valid;

  // Next state and pipeline controls; reset forces a safe frozen/bubbled pipe
  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        // FLUSH lasts one cycle and evaluates like RUN; STALL re-checks the hazard each cycle
        RUN, STALL, FLUSH: begin
          if (take) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = FLUSH;
          end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = STALL;
          end else begin
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, scoreboard shift and saturating counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q       <= state_d;
      wb_q          <= mem_q;
      mem_q         <= exe_q;
      exe_q.valid   <= id_valid & id_wen & ~idex_bubble;
      exe_q.waddr   <= id_waddr;
      exe_q.is_load <= id_is_load;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

`ifdef PIPE_FWD_EN
  // Youngest producer wins: EXE result (01) before MEM result (10)
  function automatic logic [1:0] fwd_sel(input logic in_exe, input logic in_mem);
    return in_exe ? 2'b01 : (in_mem ? 2'b10 : 2'b00);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (idex_bubble) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= fwd_sel(rs1_exe, rs1_mem);
      fwd_b <= id_use_rs2 ? fwd_sel(rs2_exe, rs2_mem) : 2'b00;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (WB stalls, WB bypassed, 2-bit counters) share one stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid, id_use_rs2, id_wen, id_is_load, exe_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_waddr;

  logic        pc_write [3];
  logic        ifid_write [3];
  logic        ifid_flush [3];
  logic        idex_bubble [3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;
`ifdef PIPE_FWD_EN
  logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1, fwd_a2, fwd_b2;
`endif

  int n_cmp, n_fail;
  int exp_stall0, exp_stall1, exp_flush;

  pipe_hazard_ctrl #(.REGFILE_BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_branch_taken(exe_branch_taken), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
    .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]),
`ifdef PIPE_FWD_EN
    .fwd_a(fwd_a0), .fwd_b(fwd_b0),
`endif
    .stall_count(sc0), .flush_count(fc0));

  pipe_hazard_ctrl #(.REGFILE_BYPASS(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_branch_taken(exe_branch_taken), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
    .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]),
`ifdef PIPE_FWD_EN
    .fwd_a(fwd_a1), .fwd_b(fwd_b1),
`endif
    .stall_count(sc1), .flush_count(fc1));

  pipe_hazard_ctrl #(.REGFILE_BYPASS(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_branch_taken(exe_branch_taken), .pc_write(pc_write[2]), .ifid_write(ifid_write[2]),
    .ifid_flush(ifid_flush[2]), .idex_bubble(idex_bubble[2]),
`ifdef PIPE_FWD_EN
    .fwd_a(fwd_a2), .fwd_b(fwd_b2),
`endif
    .stall_count(sc2), .flush_count(fc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ctl(input int i);
    return {pc_write[i], ifid_write[i], ifid_flush[i], idex_bubble[i]};
  endfunction

  function automatic logic [1:0] sat3(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                       input logic w, input logic [4:0] wa, input logic ld, input logic br);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs2 = u2;
    id_wen = w; id_waddr = wa; id_is_load = ld; exe_branch_taken = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ctl(i) !== 4'b0011) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got %b expected 0011", i, ctl(i));
      end
    end
    n_cmp++;
    if (sc0 !== 16'd0 || fc0 !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", sc0, fc0);
    end
`ifdef PIPE_FWD_EN
    n_cmp++;
    if (fwd_a0 !== 2'b00 || fwd_b0 !== 2'b00) begin
      n_fail++; $display("FAIL reset_fwd: got %b/%b expected 00/00", fwd_a0, fwd_b0);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL post_reset_ctl: got %b expected 1100", ctl(0));
    end
  endtask

  task automatic test_independent();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + 2 * i), 5'(11 + 2 * i), 1'b1, 1'b1, 5'(i + 1), 1'b0, 1'b0);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (ctl(d) !== 4'b1100) begin
          n_fail++; $display("FAIL indep_ctl dut%0d instr%0d: got %b expected 1100", d, i, ctl(d));
        end
      end
      step();
    end
    drain();
    n_cmp++;
    if (sc0 !== 16'(exp_stall0)) begin
      n_fail++; $display("FAIL indep_stall_count: got %0d expected %0d", sc0, exp_stall0);
    end
  endtask

  // add r3 then sub r4,r3,r5: 3 stalls with WB stalling, 2 with WB bypass
  task automatic test_stall_timing();
    logic [3:0] e0, e1;
    drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      e0 = (c < 3) ? 4'b0001 : 4'b1100;
      e1 = (c < 2) ? 4'b0001 : 4'b1100;
      n_cmp++;
      if (ctl(0) !== e0) begin
        n_fail++; $display("FAIL stall_ctl_nobypass cyc%0d: got %b expected %b", c, ctl(0), e0);
      end
      n_cmp++;
      if (ctl(1) !== e1) begin
        n_fail++; $display("FAIL stall_ctl_bypass cyc%0d: got %b expected %b", c, ctl(1), e1);
      end
      step();
    end
    exp_stall0 += 3;
    exp_stall1 += 2;
    drain();
    n_cmp++;
    if (sc0 !== 16'(exp_stall0)) begin
      n_fail++; $display("FAIL stall_count_nobypass: got %0d expected %0d", sc0, exp_stall0);
    end
    n_cmp++;
    if (sc1 !== 16'(exp_stall1)) begin
      n_fail++; $display("FAIL stall_count_bypass: got %0d expected %0d", sc1, exp_stall1);
    end
    n_cmp++;
    if (sc2 !== sat3(exp_stall0)) begin
      n_fail++; $display("FAIL stall_count_sat: got %0d expected %0d", sc2, sat3(exp_stall0));
    end
  endtask

  task automatic test_branch_flush();
    drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ctl(d) !== 4'b1111) begin
        n_fail++; $display("FAIL take_over_hazard dut%0d: got %b expected 1111", d, ctl(d));
      end
    end
    step();
    exp_flush++;
    drive(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL flush_target_ctl: got %b expected 1100", ctl(0));
    end
    n_cmp++;
    if (fc0 !== 16'(exp_flush) || sc0 !== 16'(exp_stall0)) begin
      n_fail++; $display("FAIL flush_counts: got flush=%0d stall=%0d expected %0d/%0d",
                         fc0, sc0, exp_flush, exp_stall0);
    end
    step();
    // squashed sub r4 must never have entered the scoreboard
    drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL squashed_dest_ctl: got %b expected 1100", ctl(0));
    end
    drain();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL take_invalid_exe_ctl: got %b expected 1100", ctl(0));
    end
    step();
    n_cmp++;
    if (fc0 !== 16'(exp_flush)) begin
      n_fail++; $display("FAIL take_invalid_exe_count: got %0d expected %0d", fc0, exp_flush);
    end
    drain();
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL r0_consumer_ctl: got %b expected 1100", ctl(0));
    end
    step();
    drain();
    n_cmp++;
    if (sc0 !== 16'(exp_stall0)) begin
      n_fail++; $display("FAIL r0_stall_count: got %0d expected %0d", sc0, exp_stall0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (ctl(0) !== 4'b1100) begin
        n_fail++; $display("FAIL b2b_advance[%0d]: got %b expected 1100", k, ctl(0));
      end
      step();
      exe_branch_taken = 1'b1;
      #1;
      n_cmp++;
      if (ctl(0) !== 4'b1111) begin
        n_fail++; $display("FAIL b2b_take[%0d]: got %b expected 1111", k, ctl(0));
      end
      step();
      exp_flush++;
    end
    drain();
    n_cmp++;
    if (fc0 !== 16'(exp_flush)) begin
      n_fail++; $display("FAIL b2b_flush_count: got %0d expected %0d", fc0, exp_flush);
    end
    n_cmp++;
    if (fc2 !== sat3(exp_flush)) begin
      n_fail++; $display("FAIL b2b_flush_sat: got %0d expected %0d", fc2, sat3(exp_flush));
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    step();
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b0001) begin
      n_fail++; $display("FAIL midstall_2nd_ctl: got %b expected 0001", ctl(0));
    end
    rst = 1'b0;
    #1;
    exp_stall0 = 0; exp_stall1 = 0; exp_flush = 0;
    n_cmp++;
    if (ctl(0) !== 4'b0011 || ctl(1) !== 4'b0011) begin
      n_fail++; $display("FAIL midstall_reset_ctl: got %b/%b expected 0011/0011", ctl(0), ctl(1));
    end
    n_cmp++;
    if (sc0 !== 16'd0 || fc0 !== 16'd0 || sc2 !== 2'd0) begin
      n_fail++; $display("FAIL midstall_reset_cnt: got %0d/%0d/%0d expected 0/0/0", sc0, fc0, sc2);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL midstall_release_ctl: got %b expected 1100", ctl(0));
    end
    step();
    drain();
    n_cmp++;
    if (sc0 !== 16'd0) begin
      n_fail++; $display("FAIL midstall_release_count: got %0d expected 0", sc0);
    end
  endtask

`ifdef PIPE_FWD_EN
  task automatic test_fwd();
    drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b0001) begin
      n_fail++; $display("FAIL load_use_stall: got %b expected 0001", ctl(0));
    end
    step();
    exp_stall0++;
    n_cmp++;
    if (fwd_a0 !== 2'b00 || fwd_b0 !== 2'b00) begin
      n_fail++; $display("FAIL fwd_bubble: got %b/%b expected 00/00", fwd_a0, fwd_b0);
    end
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL load_use_release: got %b expected 1100", ctl(0));
    end
    step();
    n_cmp++;
    if (fwd_a0 !== 2'b10 || fwd_b0 !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem: got %b/%b expected 10/10", fwd_a0, fwd_b0);
    end
    drive(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (ctl(0) !== 4'b1100) begin
      n_fail++; $display("FAIL fwd_exe_nostall: got %b expected 1100", ctl(0));
    end
    step();
    n_cmp++;
    if (fwd_a0 !== 2'b01 || fwd_b0 !== 2'b00) begin
      n_fail++; $display("FAIL fwd_exe: got %b/%b expected 01/00", fwd_a0, fwd_b0);
    end
    drain();
    n_cmp++;
    if (sc0 !== 16'(exp_stall0)) begin
      n_fail++; $display("FAIL fwd_stall_count: got %0d expected %0d", sc0, exp_stall0);
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0;
    exp_stall0 = 0; exp_stall1 = 0; exp_flush = 0;
    rst = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_independent();
`ifndef PIPE_FWD_EN
    test_stall_timing();
    test_stall_timing();
`endif
    test_branch_flush();
    test_r0();
    test_back_to_back();
`ifndef PIPE_FWD_EN
    test_reset_mid_stall();
`endif
`ifdef PIPE_FWD_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
